// File: rtl/fetch_receive_ooo_pkg.sv
// rtl/fetch_receive_ooo_pkg.sv - shared front-end constants and fetch queue entry layout
package fetch_receive_ooo_pkg;

  localparam int FE_XLEN   = 64;
  localparam int FE_INST_W = 32;
  localparam int FE_DEPTH  = 4;
  localparam int FE_CNT_W  = 3;

  // One in-flight I-cache request: the PC and its NLP BTB hit flag.
  typedef struct packed {
    logic [FE_XLEN-1:0] pc;
    logic               btb_hit;
  } fetch_entry_t;

  // Counter width able to hold 0..depth inclusive.
  function automatic int fe_cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_pc_queue.sv
// rtl/fetch_pc_queue.sv - circular FIFO of in-flight fetch PCs with count and clear
module fetch_pc_queue
  import fetch_receive_ooo_pkg::*;
#(
  parameter int W     = FE_XLEN + 1,
  parameter int DEPTH = FE_DEPTH,
  parameter int CNT_W = FE_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap from the last slot back to slot zero.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Next-state for storage, pointers and occupancy; clear wins over push/pop.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/fetch_receive_ooo.sv
// rtl/fetch_receive_ooo.sv - pairs in-order I-cache responses with issued PCs for decode
module fetch_receive_ooo
  import fetch_receive_ooo_pkg::*;
#(
  parameter int XLEN   = FE_XLEN,
  parameter int INST_W = FE_INST_W,
  parameter int DEPTH  = FE_DEPTH,
  parameter int CNT_W  = FE_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_issue_valid,
  output logic              fetch_issue_ready,
  input  logic [XLEN-1:0]   fetch_issue_PC,
  input  logic              fetch_issue_NLP_BTB_hit,
  input  logic              fetch_response_valid,
  output logic              fetch_response_ready,
  input  logic [INST_W-1:0] fetch_response_instruction,
  input  logic              fetch_flush,
  output logic              decode_valid,
  input  logic              decode_ready,
  output logic [XLEN-1:0]   decode_PC,
  output logic [INST_W-1:0] decode_instruction,
  output logic              decode_NLP_BTB_hit
);

  localparam int ENTRY_W = XLEN + 1;

  logic [CNT_W-1:0]   q_count;
  logic [ENTRY_W-1:0] q_head;
  logic [CNT_W:0]     occupancy;
  logic               issue_fire;
  logic               resp_fire;
  logic               drop_fire;
  logic               pop_fire;

  logic [CNT_W-1:0]   drop_count_q, drop_count_d;
  logic               out_valid_q, out_valid_d;
  logic [XLEN-1:0]    out_pc_q, out_pc_d;
  logic [INST_W-1:0]  out_inst_q, out_inst_d;
  logic               out_hit_q, out_hit_d;

  // Outstanding requests include those already flushed but not yet returned.
  assign occupancy = {1'b0, q_count} + {1'b0, drop_count_q};

  // Handshakes; issue_ready is held low while reset is asserted.
  always_comb begin
    fetch_issue_ready    = reset && (occupancy < (CNT_W+1)'(DEPTH)) && !fetch_flush;
    fetch_response_ready = (drop_count_q != '0) ||
                           ((q_count != '0) && (!out_valid_q || decode_ready));
    issue_fire = fetch_issue_valid && fetch_issue_ready;
    resp_fire  = fetch_response_valid && fetch_response_ready;
    drop_fire  = resp_fire && (drop_count_q != '0);
    pop_fire   = resp_fire && (drop_count_q == '0);
  end

  fetch_pc_queue #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_pc_queue (
    .clock     (clock),
    .reset     (reset),
    .clear     (fetch_flush),
    .push      (issue_fire),
    .push_data ({fetch_issue_PC, fetch_issue_NLP_BTB_hit}),
    .pop       (pop_fire),
    .head_data (q_head),
    .count     (q_count)
  );

  // Drop counter: a flush converts every live queue entry into a response to absorb.
  always_comb begin
    drop_count_d = drop_count_q - CNT_W'(drop_fire);
    if (fetch_flush) begin
      drop_count_d = drop_count_q + q_count - CNT_W'(pop_fire) - CNT_W'(drop_fire);
    end
  end

  // Output register: load on a live response, empty on consume or flush.
  always_comb begin
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;
    out_hit_d   = out_hit_q;
    if (fetch_flush) begin
      out_valid_d = 1'b0;
    end else if (pop_fire) begin
      out_valid_d = 1'b1;
      out_pc_d    = q_head[ENTRY_W-1:1];
      out_inst_d  = fetch_response_instruction;
      out_hit_d   = q_head[0];
    end else if (decode_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drop_count_q <= '0;
      out_valid_q  <= 1'b0;
      out_pc_q     <= '0;
      out_inst_q   <= '0;
      out_hit_q    <= 1'b0;
    end else begin
      drop_count_q <= drop_count_d;
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      out_inst_q   <= out_inst_d;
      out_hit_q    <= out_hit_d;
    end
  end

  assign decode_valid       = out_valid_q;
  assign decode_PC          = out_pc_q;
  assign decode_instruction = out_inst_q;
  assign decode_NLP_BTB_hit = out_hit_q;

endmodule

// File: tb/tb_fetch_receive_ooo.sv
// tb/tb_fetch_receive_ooo.sv - scoreboard bench for fetch_receive_ooo
module tb_fetch_receive_ooo;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_issue_valid = 1'b0;
  logic        fetch_issue_ready;
  logic [63:0] fetch_issue_PC = '0;
  logic        fetch_issue_NLP_BTB_hit = 1'b0;
  logic        fetch_response_valid = 1'b0;
  logic        fetch_response_ready;
  logic [31:0] fetch_response_instruction = '0;
  logic        fetch_flush = 1'b0;
  logic        decode_valid;
  logic        decode_ready = 1'b0;
  logic [63:0] decode_PC;
  logic [31:0] decode_instruction;
  logic        decode_NLP_BTB_hit;

  fetch_receive_ooo dut (
    .clock                      (clock),
    .reset                      (reset),
    .fetch_issue_valid          (fetch_issue_valid),
    .fetch_issue_ready          (fetch_issue_ready),
    .fetch_issue_PC             (fetch_issue_PC),
    .fetch_issue_NLP_BTB_hit    (fetch_issue_NLP_BTB_hit),
    .fetch_response_valid       (fetch_response_valid),
    .fetch_response_ready       (fetch_response_ready),
    .fetch_response_instruction (fetch_response_instruction),
    .fetch_flush                (fetch_flush),
    .decode_valid               (decode_valid),
    .decode_ready               (decode_ready),
    .decode_PC                  (decode_PC),
    .decode_instruction         (decode_instruction),
    .decode_NLP_BTB_hit         (decode_NLP_BTB_hit)
  );

  always #5 clock = ~clock;

  // Reference model: each outstanding request is remembered in issue order and
  // marked stale when a flush overtakes it; every response retires the oldest one.
  typedef struct {
    logic [63:0] pc;
    logic        hit;
    bit          stale;
  } req_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        hit;
  } out_t;

  req_t outq[$];
  out_t expq[$];
  bit   model_out_valid = 1'b0;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus, starting 1 time unit after a rising edge.
  task automatic step(input bit iv, input logic [63:0] pc, input bit hit,
                      input bit rv_in, input logic [31:0] instr,
                      input bit fl, input bit dr);
    bit   rv;
    bit   exp_ir;
    bit   exp_rr;
    bit   deliver;
    req_t e;
    out_t o;
    rv = rv_in && (outq.size() > 0);
    fetch_issue_valid          = iv;
    fetch_issue_PC             = pc;
    fetch_issue_NLP_BTB_hit    = hit;
    fetch_response_valid       = rv;
    fetch_response_instruction = instr;
    fetch_flush                = fl;
    decode_ready               = dr;
    @(negedge clock);
    exp_ir = (outq.size() < DEPTH) && !fl;
    exp_rr = (outq.size() > 0) && (outq[0].stale || !model_out_valid || dr);
    check("issue_ready", 64'(fetch_issue_ready), 64'(exp_ir));
    check("response_ready", 64'(fetch_response_ready), 64'(exp_rr));
    check("decode_valid", 64'(decode_valid), 64'(model_out_valid));
    deliver = 1'b0;
    if (rv && exp_rr) begin
      e = outq.pop_front();
      if (!e.stale && !fl) begin
        deliver = 1'b1;
        o.pc = e.pc;
        o.instr = instr;
        o.hit = e.hit;
        expq.push_back(o);
      end
    end
    if (iv && exp_ir) begin
      e.pc = pc;
      e.hit = hit;
      e.stale = 1'b0;
      outq.push_back(e);
    end
    if (fl) begin
      foreach (outq[i]) outq[i].stale = 1'b1;
      if (model_out_valid && !dr && expq.size() > 0) void'(expq.pop_back());
      model_out_valid = 1'b0;
    end else if (deliver) begin
      model_out_valid = 1'b1;
    end else if (dr) begin
      model_out_valid = 1'b0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [63:0] pc, input bit hit, input bit dr);
    step(1'b1, pc, hit, 1'b0, 32'h0, 1'b0, dr);
  endtask

  task automatic respond(input logic [31:0] instr, input bit dr);
    step(1'b0, 64'h0, 1'b0, 1'b1, instr, 1'b0, dr);
  endtask

  task automatic idle(input bit dr);
    step(1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b0, dr);
  endtask

  // Monitor: every consumed decode output must match the oldest expected one.
  initial begin
    out_t o;
    forever begin
      @(posedge clock);
      #2;
      if (reset && decode_valid && decode_ready) begin
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL decode_unexpected actual_pc=%0h required=none at %0t", decode_PC, $time);
        end else begin
          o = expq.pop_front();
          check("decode_PC", decode_PC, o.pc);
          check("decode_instruction", 64'(decode_instruction), 64'(o.instr));
          check("decode_hit", 64'(decode_NLP_BTB_hit), 64'(o.hit));
        end
      end
    end
  end

  // Stimulus.
  initial begin
    #3;
    check("rst_decode_valid", 64'(decode_valid), 64'h0);
    check("rst_decode_PC", decode_PC, 64'h0);
    check("rst_decode_instruction", 64'(decode_instruction), 64'h0);
    check("rst_decode_hit", 64'(decode_NLP_BTB_hit), 64'h0);
    check("rst_issue_ready", 64'(fetch_issue_ready), 64'h0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Basic pairing.
    issue(64'h0, 1'b0, 1'b1);
    issue(64'h4, 1'b1, 1'b1);
    respond(32'h0000_0013, 1'b1);
    respond(32'h0010_0093, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Full and wrap-around.
    issue(64'h0, 1'b0, 1'b1);
    issue(64'h4, 1'b0, 1'b1);
    issue(64'h8, 1'b1, 1'b1);
    issue(64'hC, 1'b0, 1'b1);
    issue(64'hDEAD, 1'b1, 1'b1);
    respond(32'hA000_0000, 1'b1);
    issue(64'h10, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) respond(32'hA000_0001 + 32'(i), 1'b1);
    idle(1'b1);

    // Backpressure.
    issue(64'h20, 1'b0, 1'b0);
    issue(64'h24, 1'b1, 1'b0);
    respond(32'hB000_0000, 1'b0);
    respond(32'hB000_0001, 1'b0);
    respond(32'hB000_0001, 1'b0);
    respond(32'hB000_0001, 1'b1);
    idle(1'b1);

    // Flush with three outstanding.
    issue(64'h30, 1'b0, 1'b1);
    issue(64'h34, 1'b0, 1'b1);
    issue(64'h38, 1'b0, 1'b1);
    step(1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) respond(32'hC000_0000 + 32'(i), 1'b1);
    issue(64'h100, 1'b1, 1'b1);
    respond(32'hC000_0100, 1'b1);
    idle(1'b1);

    // Flush coincident with a response.
    issue(64'h40, 1'b0, 1'b1);
    issue(64'h44, 1'b1, 1'b1);
    step(1'b0, 64'h0, 1'b0, 1'b1, 32'hD000_0000, 1'b1, 1'b1);
    respond(32'hD000_0001, 1'b1);
    issue(64'h200, 1'b0, 1'b1);
    respond(32'hD000_0200, 1'b1);
    idle(1'b1);

    // Asynchronous reset with two outstanding and a held output.
    issue(64'h50, 1'b0, 1'b0);
    issue(64'h54, 1'b0, 1'b0);
    issue(64'h58, 1'b0, 1'b0);
    respond(32'hE000_0000, 1'b0);
    check("pre_reset_decode_valid", 64'(decode_valid), 64'h1);
    fetch_issue_valid    = 1'b0;
    fetch_response_valid = 1'b0;
    decode_ready         = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("async_decode_valid", 64'(decode_valid), 64'h0);
    check("async_issue_ready", 64'(fetch_issue_ready), 64'h0);
    check("async_response_ready", 64'(fetch_response_ready), 64'h0);
    outq.delete();
    expq.delete();
    model_out_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    idle(1'b1);
    issue(64'h300, 1'b1, 1'b1);
    respond(32'hE000_0300, 1'b1);
    idle(1'b1);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      step(($urandom % 4) != 0, {$urandom, $urandom} & ~64'h3, 1'($urandom),
           ($urandom % 3) != 0, $urandom, ($urandom % 16) == 0, ($urandom % 4) != 0);
    end

    // Drain.
    for (int n = 0; n < 12; n++) respond($urandom, 1'b1);
    idle(1'b1);
    idle(1'b1);
    check("scoreboard_empty", 64'(expq.size()), 64'h0);
    check("model_empty", 64'(outq.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_receive_ooo.md
Name: fetch_receive_ooo

Overview:
- Receiving end of the fetch-issue → fetch-receive interface in the out-of-order front end.
- Accepts issued PCs plus their NLP BTB-hit flag, and queues them as in-flight I-cache requests.
- Pairs each in-order I-cache response with its queued PC and presents {PC, instruction, BTB hit} to decode through a one-entry output register.
- On a pipeline flush, discards every outstanding request and silently absorbs the stale responses still in flight.

Parameters:
- XLEN, 64, PC width.
- INST_W, 32, instruction width.
- DEPTH, 4, maximum outstanding requests (power of two, ≥2).
- CNT_W, 3, counter width, equal to clog2(DEPTH)+1.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- fetch_issue_valid  in  1  issue side has a PC to hand over.
- fetch_issue_ready  out  1  block can accept an issued PC this cycle.
- fetch_issue_PC  in  XLEN  PC of the I-cache request.
- fetch_issue_NLP_BTB_hit  in  1  NLP BTB hit flag for that PC.
- fetch_response_valid  in  1  I-cache returns an instruction; responses arrive in request order.
- fetch_response_ready  out  1  block accepts the response this cycle.
- fetch_response_instruction  in  INST_W  returned instruction word.
- fetch_flush  in  1  redirect: drop all queued and in-flight fetches.
- decode_valid  out  1  output register holds a valid instruction.
- decode_ready  in  1  decode consumes the output this cycle.
- decode_PC  out  XLEN  PC of the presented instruction.
- decode_instruction  out  INST_W  presented instruction.
- decode_NLP_BTB_hit  out  1  BTB hit flag of the presented instruction.

Behaviour:
- Reset (reset=0, asynchronous):
  - queue count, drop_count and pointers clear to 0;
  - decode_valid=0; decode_PC, decode_instruction and decode_NLP_BTB_hit = 0;
  - fetch_issue_ready=0 while reset is asserted.
- Reset mid-operation loses all in-flight state. No response is forwarded after reset release until a new issue occurs.
- Issue handshake:
  - fetch_issue_ready = (count + drop_count < DEPTH) && !fetch_flush.
  - On valid && ready, push {PC, hit} at the tail and increment count.
- Response ready:
  - fetch_response_ready = (drop_count != 0) || (count != 0 && (!decode_valid || decode_ready)).
  - It is a function of registered state and decode_ready only.
- Response accepted with drop_count != 0:
  - decrement drop_count and discard the data;
  - the queue and the output register are unchanged by the response.
- Response accepted with drop_count == 0:
  - pop the queue head;
  - next cycle the output register holds {head PC, response instruction, head hit} and decode_valid=1.
  - Latency from response to decode is exactly 1 cycle.
- Output register:
  - cleared (decode_valid→0) on decode_ready unless reloaded in the same cycle;
  - a simultaneous consume and reload gives back-to-back output at one instruction per cycle.
- Simultaneous issue push and response pop: count is unchanged and pointers advance independently.
- Flush cycle (fetch_flush=1):
  - no issue accepted;
  - decode_valid→0 next cycle;
  - queue count→0 and pointers reset;
  - drop_count_next = drop_count + count − (response accepted && drop_count == 0 ? 1 : 0), and additionally −1 if a response is accepted with drop_count != 0.
  - Net effect: every request outstanding before the flush is absorbed exactly once.
- Invariant: count + drop_count ≤ DEPTH at all times.
- Protocol error: fetch_response_valid with count == 0 and drop_count == 0 is not accepted (ready=0). Bench asserts this never occurs.
- Ordering: output order always equals issue order for non-flushed requests.

Decomposition:
- Shared front-end include holds:
  - the queue entry layout {XLEN PC, 1-bit hit};
  - DEPTH/CNT_W defaults;
  - the INST_W constant, shared with fetch_issue_ooo.
- One sub-module: fetch_pc_queue.
  - Synchronous-push/pop circular FIFO of DEPTH entries with count and a clear input.
  - The pointer wrap-around at DEPTH lives there.
- The drop counter, handshake logic and output register stay in fetch_receive_ooo.

Test Plan:
- Basic pairing: issue PCs 0x0 and 0x4 (hit=0,1); respond 0x00000013 then 0x00100093 with decode_ready=1 → decode outputs (0x0, 0x13, 0) then (0x4, 0x100093, 1) on consecutive cycles, each 1 cycle after its response.
- Full and wrap-around: issue 4 PCs with no response → fetch_issue_ready=0 at count=4. Respond once, then issue 0x10 → queue wraps. Remaining outputs stay in PC order 0x4, 0x8, 0xC, 0x10.
- Backpressure: decode_ready=0 with decode_valid=1 → fetch_response_ready=0 and outputs stable. Raise decode_ready → next response loads the same cycle the old output is consumed.
- Flush with 3 outstanding: assert fetch_flush one cycle → decode_valid=0, drop_count=3. The next 3 responses are accepted and discarded; a newly issued PC 0x100 then appears with its response as the first decode output.
- Flush coincident with a response (count=2, drop_count=0): drop_count becomes 1. Exactly one later response is discarded and no stale PC reaches decode.
- Async reset mid-stream (2 outstanding, decode_valid=1): drive reset=0 between edges → decode_valid=0 immediately and fetch_issue_ready=0. After release, fetch_issue_ready=1 and count=0.
